// File: rtl/ff_bank_cfg_ctrl.sv
`default_nettype none
// ============================================================================
// ff_bank_cfg_ctrl : per-element mode loader and GSR sequencer for an FF bank
// Optional feature macro: FF_CFG_READBACK_EN (registered per-element readback)
// Revision: 1.0
// ============================================================================
module ff_bank_cfg_ctrl #(
  parameter int N_FF       = 8,
  parameter int GSR_CYCLES = 4,
  parameter int IDX_W      = $clog2(N_FF)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             cfg_valid,
  input  logic [3:0]       cfg_data,
  output logic             cfg_ready,
  output logic [IDX_W-1:0] cfg_idx,
  output logic [N_FF-1:0]  syncasync_01,
  output logic [N_FF-1:0]  fflat_01,
  output logic [N_FF-1:0]  init01,
  output logic [N_FF-1:0]  srhilo,
  output logic             gsr,
  output logic             run
`ifdef FF_CFG_READBACK_EN
  ,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [3:0]       rd_data
`endif
);

  localparam int c_CNT_W = (GSR_CYCLES > 1) ? $clog2(GSR_CYCLES) : 1;
  localparam logic [IDX_W-1:0]   c_LAST_IDX = IDX_W'(N_FF - 1);
  localparam logic [IDX_W-1:0]   c_IDX_ONE  = IDX_W'(1);
  localparam logic [c_CNT_W-1:0] c_CNT_INIT = c_CNT_W'(GSR_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_GSR  = 2'd2,
    S_RUN  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [c_CNT_W-1:0] cnt_q, cnt_d;
  logic [N_FF-1:0]    sa_q, sa_d;
  logic [N_FF-1:0]    fl_q, fl_d;
  logic [N_FF-1:0]    in_q, in_d;
  logic [N_FF-1:0]    sr_q, sr_d;
  logic               gsr_q, gsr_d;
  logic               run_q, run_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      sa_q    <= '0;
      fl_q    <= '0;
      in_q    <= '0;
      sr_q    <= '0;
      gsr_q   <= 1'b1;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      sa_q    <= sa_d;
      fl_q    <= fl_d;
      in_q    <= in_d;
      sr_q    <= sr_d;
      gsr_q   <= gsr_d;
      run_q   <= run_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    sa_d    = sa_q;
    fl_d    = fl_q;
    in_d    = in_q;
    sr_d    = sr_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          idx_d   = '0;
        end
      end
      S_LOAD: begin
        // cfg_ready is implied by being in LOAD, so cfg_valid alone is the handshake
        if (cfg_valid) begin
          sa_d[idx_q] = cfg_data[3];
          fl_d[idx_q] = cfg_data[2];
          in_d[idx_q] = cfg_data[1];
          sr_d[idx_q] = cfg_data[0];
          if (idx_q == c_LAST_IDX) begin
            idx_d   = '0;
            cnt_d   = c_CNT_INIT;
            state_d = S_GSR;
          end else begin
            idx_d = idx_q + c_IDX_ONE;
          end
        end
      end
      S_GSR: begin
        if (cnt_q == '0) begin
          state_d = S_RUN;
        end else begin
          cnt_d = cnt_q - c_CNT_ONE;
        end
      end
      S_RUN: begin
        if (start) begin
          state_d = S_LOAD;
          idx_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Registering from the next state keeps gsr glitch-free and aligns the gsr fall with run rise
    gsr_d = (state_d != S_RUN);
    run_d = (state_d == S_RUN);
  end

  assign cfg_ready    = (state_q == S_LOAD);
  assign cfg_idx      = idx_q;
  assign syncasync_01 = sa_q;
  assign fflat_01     = fl_q;
  assign init01       = in_q;
  assign srhilo       = sr_q;
  assign gsr          = gsr_q;
  assign run          = run_q;

`ifdef FF_CFG_READBACK_EN
  logic [3:0] rd_data_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data_q <= '0;
    end else if (int'(rd_idx) < N_FF) begin
      rd_data_q <= {sa_q[rd_idx], fl_q[rd_idx], in_q[rd_idx], sr_q[rd_idx]};
    end else begin
      rd_data_q <= '0;
    end
  end

  assign rd_data = rd_data_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ff_bank_cfg_ctrl.sv
`default_nettype none
// Testbench for ff_bank_cfg_ctrl: table-driven loads plus handshake scoreboard.
module tb_ff_bank_cfg_ctrl;

  localparam int N_FF       = 8;
  localparam int GSR_CYCLES = 4;
  localparam int IDX_W      = 3;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic             cfg_valid = 1'b0;
  logic [3:0]       cfg_data = 4'h0;
  logic             cfg_ready;
  logic [IDX_W-1:0] cfg_idx;
  logic [N_FF-1:0]  syncasync_01, fflat_01, init01, srhilo;
  logic             gsr, run;
`ifdef FF_CFG_READBACK_EN
  logic [IDX_W-1:0] rd_idx = '0;
  logic [3:0]       rd_data;
`endif

  ff_bank_cfg_ctrl #(.N_FF(N_FF), .GSR_CYCLES(GSR_CYCLES), .IDX_W(IDX_W)) dut (
    .clk(clk), .reset(reset), .start(start),
    .cfg_valid(cfg_valid), .cfg_data(cfg_data),
    .cfg_ready(cfg_ready), .cfg_idx(cfg_idx),
    .syncasync_01(syncasync_01), .fflat_01(fflat_01),
    .init01(init01), .srhilo(srhilo),
    .gsr(gsr), .run(run)
`ifdef FF_CFG_READBACK_EN
    , .rd_idx(rd_idx), .rd_data(rd_data)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]       data;
    logic [IDX_W-1:0] exp_idx;
    logic             exp_ready;
  } vec_t;

  typedef struct {
    logic [IDX_W-1:0] idx;
    logic [3:0]       data;
  } sb_t;

  vec_t             tbl[N_FF];
  sb_t              sb_q[$];
  int               n_checks = 0;
  int               n_fail = 0;
  logic [N_FF-1:0]  m_sa = '0, m_fl = '0, m_in = '0, m_sr = '0;
  logic [IDX_W-1:0] m_idx = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_vecs(input string name);
    check({name, "_vecs"}, 64'({syncasync_01, fflat_01, init01, srhilo}),
          64'({m_sa, m_fl, m_in, m_sr}));
  endtask

  task automatic chk_ctrl(input string name, input logic g, input logic r, input logic rdy,
                          input logic [IDX_W-1:0] idx);
    check({name, "_ctrl"}, 64'({gsr, run, cfg_ready, cfg_idx}), 64'({g, r, rdy, idx}));
  endtask

  task automatic pop_check();
    sb_t e;
    if (sb_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL sb_empty: got 0 entries, expected at least 1");
      return;
    end
    e = sb_q.pop_front();
    check("hs_bits", 64'({syncasync_01[e.idx], fflat_01[e.idx], init01[e.idx], srhilo[e.idx]}),
          64'(e.data));
    m_sa[e.idx] = e.data[3];
    m_fl[e.idx] = e.data[2];
    m_in[e.idx] = e.data[1];
    m_sr[e.idx] = e.data[0];
    m_idx = (m_idx == IDX_W'(N_FF - 1)) ? '0 : IDX_W'(m_idx + 1);
    check("hs_idx", 64'(cfg_idx), 64'(m_idx));
    chk_vecs("hs");
  endtask

  task automatic send(input logic [3:0] d);
    cfg_valid = 1'b1;
    cfg_data  = d;
    sb_q.push_back('{idx: m_idx, data: d});
    step();
    cfg_valid = 1'b0;
    pop_check();
  endtask

  task automatic do_start(input string name);
    start = 1'b1;
    step();
    start = 1'b0;
    m_idx = '0;
    chk_ctrl(name, 1'b1, 1'b0, 1'b1, '0);
  endtask

  // Call at the sample point just after the last handshake edge; optional start in GSR
  task automatic gsr_seq(input string name, input logic poke_start);
    chk_ctrl({name, "_gsr0"}, 1'b1, 1'b0, 1'b0, '0);
    for (int k = 1; k <= GSR_CYCLES; k++) begin
      start = poke_start && (k == 1);
      step();
      start = 1'b0;
      check({name, "_gsr_run"}, 64'({gsr, run, cfg_ready}),
            (k < GSR_CYCLES) ? 64'(3'b100) : 64'(3'b010));
    end
  endtask

  task automatic table_load(input string name);
    for (int i = 0; i < N_FF; i++) begin
      check({name, "_tbl_idx"}, 64'({cfg_ready, cfg_idx}),
            64'({tbl[i].exp_ready, tbl[i].exp_idx}));
      send(tbl[i].data);
    end
  endtask

  task automatic chk_table_vecs(input string name);
    logic [N_FF-1:0] e_sa, e_fl, e_in, e_sr;
    for (int i = 0; i < N_FF; i++) begin
      e_sa[i] = tbl[i].data[3];
      e_fl[i] = tbl[i].data[2];
      e_in[i] = tbl[i].data[1];
      e_sr[i] = tbl[i].data[0];
    end
    check({name, "_final"}, 64'({syncasync_01, fflat_01, init01, srhilo}),
          64'({e_sa, e_fl, e_in, e_sr}));
  endtask

  initial begin
    logic [3:0] words [N_FF];
    int         hs;
    logic       v;
    logic [3:0] d;
    logic       poked;

    words = '{4'hF, 4'h0, 4'hA, 4'h5, 4'h1, 4'h2, 4'h4, 4'h8};
    for (int i = 0; i < N_FF; i++) begin
      tbl[i] = '{data: words[i], exp_idx: IDX_W'(i), exp_ready: 1'b1};
    end

    // Reset pulsed mid-cycle, then idle with no stimulus
    #2 reset = 1'b1;
    #5 reset = 1'b0;
    for (int c = 0; c < 20; c++) begin
      step();
      chk_ctrl("idle", 1'b1, 1'b0, 1'b0, '0);
      chk_vecs("idle");
    end

    // cfg_valid in IDLE writes nothing
    cfg_valid = 1'b1;
    cfg_data  = 4'h7;
    for (int c = 0; c < 3; c++) begin
      step();
      chk_ctrl("idle_valid", 1'b1, 1'b0, 1'b0, '0);
      chk_vecs("idle_valid");
    end
    cfg_valid = 1'b0;

    // Full back-to-back load
    do_start("start1");
    table_load("load1");
    gsr_seq("load1", 1'b0);
    chk_table_vecs("load1");
`ifdef FF_CFG_READBACK_EN
    rd_idx = 3'd2;
    step();
    check("rd_idx2", 64'(rd_data), 64'(tbl[2].data));
    rd_idx = 3'd7;
    step();
    check("rd_idx7", 64'(rd_data), 64'(tbl[7].data));
`endif

    // Reconfigure from RUN with random stalls; start at index 3 and in GSR is ignored
    do_start("start2");
    hs = 0;
    poked = 1'b0;
    for (int c = 0; c < 200 && hs < N_FF; c++) begin
      v = 1'($urandom_range(0, 1));
      d = 4'($urandom_range(0, 15));
      cfg_valid = v;
      cfg_data  = d;
      start = (m_idx == 3'd3) && !poked;
      if (start) poked = 1'b1;
      if (v) sb_q.push_back('{idx: m_idx, data: d});
      step();
      cfg_valid = 1'b0;
      start = 1'b0;
      if (v) begin
        pop_check();
        hs++;
      end else begin
        check("stall_idx", 64'({cfg_ready, cfg_idx}), 64'({1'b1, m_idx}));
        chk_vecs("stall");
      end
    end
    check("stall_done", 64'(hs), 64'(N_FF));
    gsr_seq("stall", 1'b1);
    chk_vecs("stall_run");

    // cfg_valid in RUN writes nothing
    cfg_valid = 1'b1;
    cfg_data  = 4'h7;
    for (int c = 0; c < 3; c++) begin
      step();
      chk_ctrl("run_valid", 1'b0, 1'b1, 1'b0, '0);
      chk_vecs("run_valid");
    end
    cfg_valid = 1'b0;

    // Reconfigure then abandon with reset at index 1
    do_start("start3");
    send(4'h0);
    #2 reset = 1'b1;
    #1;
    m_sa = '0; m_fl = '0; m_in = '0; m_sr = '0; m_idx = '0;
    sb_q.delete();
    chk_ctrl("async_rst", 1'b1, 1'b0, 1'b0, '0);
    chk_vecs("async_rst");
    #1 reset = 1'b0;
    step();
    chk_ctrl("post_rst", 1'b1, 1'b0, 1'b0, '0);
    chk_vecs("post_rst");

    // Fresh full pass after reset
    do_start("start4");
    table_load("load4");
    gsr_seq("load4", 1'b0);
    chk_table_vecs("load4");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
